sc_fifo: RTL and testbench

Single-clock, parametrised FIFO for the datapath glue between NTT stages and the HPS bridge, succeeding the team's dual-clock gray-pointer FIFO wherever both sides share one clock. It adds a selectable show-ahead read mode, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. Depth, width and thresholds are set by parameters. Storage is an inferred simple-dual-port RAM with a registered read port.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/sc_fifo_if.sv | 35 +++
 rtl/sc_fifo_ram.sv | 41 ++++
 rtl/sc_fifo.sv | 130 +++++++++++++
 tb/tb_sc_fifo.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
//   FIFO_MODE_NORMAL    : read data follows rd_req by one cycle
//   FIFO_MODE_SHOWAHEAD : head word is presented before rd_req
//   clog2               : ceiling log2, shared with the dual-clock FIFO
package fifo_pkg;

    localparam int FIFO_MODE_NORMAL    = 0;
    localparam int FIFO_MODE_SHOWAHEAD = 1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sc_fifo_if.sv
// Handshake bundle for sc_fifo.
//   master : producer/consumer side (drives sclr, wr_dat, wr_req, rd_req)
//   slave  : FIFO side (drives wr_full, rd_dat, rd_empty, used, almost_full,
//            almost_empty, overflow, underflow)
interface sc_fifo_if #(
    parameter int DAT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
);

    logic                  sclr;
    logic [DAT_WIDTH-1:0]  wr_dat;
    logic                  wr_req;
    logic                  wr_full;
    logic                  rd_req;
    logic [DAT_WIDTH-1:0]  rd_dat;
    logic                  rd_empty;
    logic [ADDR_WIDTH:0]   used;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output sclr, wr_dat, wr_req, rd_req,
        input  wr_full, rd_dat, rd_empty, used,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  sclr, wr_dat, wr_req, rd_req,
        output wr_full, rd_dat, rd_empty, used,
               almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/sc_fifo_ram.sv
// Simple-dual-port RAM: one write port, one registered read port with enable.
//   clk, aclr_n    : clock, async active-low reset (read register only)
//   clr            : synchronous clear of the read register
//   we/wr_addr/wr_dat : write port
//   re/rd_addr     : read enable/address; rd_dat is the read register
// The same address is never read and written in one cycle, so no
// read-during-write behaviour is defined.
module sc_fifo_ram #(
    parameter int DAT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DAT_WIDTH-1:0]  wr_dat,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DAT_WIDTH-1:0]  rd_dat
);

    logic [DAT_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rd_dat <= '0;
        end else if (clr) begin
            rd_dat <= '0;
        end else if (re) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO with normal or show-ahead read, almost flags and sticky
// overflow/underflow.
//   clk    : clock, rising edge
//   aclr_n : asynchronous active-low reset
//   bus    : sc_fifo_if slave (sclr, write/read handshakes, status flags)
module sc_fifo
    import fifo_pkg::*;
#(
    parameter int DAT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int SHOW_AHEAD = FIFO_MODE_NORMAL,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic      clk,
    input  logic      aclr_n,
    sc_fifo_if.slave  bus
);

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam bit                  SA        = (SHOW_AHEAD == FIFO_MODE_SHOWAHEAD);

    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $error("sc_fifo: illegal thresholds AE_LEVEL=%0d AF_LEVEL=%0d DEPTH=%0d",
               AE_LEVEL, AF_LEVEL, DEPTH);
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   used_q;
    logic                  q_valid;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_re;
    logic                  ram_has_data;
    logic [ADDR_WIDTH:0]   ram_words;
    logic                  q_valid_next;

    always_comb begin
        full         = (used_q == DEPTH_CNT);
        // used includes the word parked in the output register; the RAM
        // holds only the remainder. q_valid is always 0 in normal mode.
        ram_words    = used_q - {{ADDR_WIDTH{1'b0}}, q_valid};
        ram_has_data = (ram_words != '0);
        empty        = SA ? !q_valid : (used_q == '0);
        wr_acc       = bus.wr_req && !full  && !bus.sclr;
        rd_acc       = bus.rd_req && !empty && !bus.sclr;
        ram_re       = 1'b0;
        q_valid_next = 1'b0;
        if (SA) begin
            // Prefetch into an empty output register, or refill on pop so
            // back-to-back pops see no bubble.
            ram_re       = !bus.sclr && ram_has_data && (!q_valid || rd_acc);
            q_valid_next = ram_re || (q_valid && !rd_acc);
        end else begin
            ram_re       = rd_acc;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            used_q      <= '0;
            q_valid     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.sclr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            used_q      <= '0;
            q_valid     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                used_q <= used_q + CNT_ONE;
            end else if (!wr_acc && rd_acc) begin
                used_q <= used_q - CNT_ONE;
            end
            q_valid <= q_valid_next;
            if (bus.wr_req && full) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_req && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    sc_fifo_ram #(
        .DAT_WIDTH  (DAT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .aclr_n  (aclr_n),
        .clr     (bus.sclr),
        .we      (wr_acc),
        .wr_addr (wr_ptr),
        .wr_dat  (bus.wr_dat),
        .re      (ram_re),
        .rd_addr (rd_ptr),
        .rd_dat  (bus.rd_dat)
    );

    assign bus.wr_full      = full;
    assign bus.rd_empty     = empty;
    assign bus.used         = used_q;
    assign bus.almost_full  = (used_q >= AF_CNT);
    assign bus.almost_empty = (used_q <= AE_CNT);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sc_fifo.sv
// Bench for sc_fifo: a normal-mode and a show-ahead instance (depth 8,
// AF_LEVEL 6, AE_LEVEL 2) share one stimulus stream. A count-level model
// predicts status; accepted writes feed per-instance scoreboards that a
// negedge monitor drains on each read handshake.
module tb_sc_fifo;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk    = 1'b0;
    logic          aclr_n = 1'b0;
    logic          sclr   = 1'b0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic [DW-1:0] wr_dat = '0;

    int vectors     = 0;
    int miscompares = 0;

    sc_fifo_if #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW)) ifn ();
    sc_fifo_if #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW)) ifs ();

    assign ifn.sclr   = sclr;
    assign ifn.wr_req = wr_req;
    assign ifn.wr_dat = wr_dat;
    assign ifn.rd_req = rd_req;
    assign ifs.sclr   = sclr;
    assign ifs.wr_req = wr_req;
    assign ifs.wr_dat = wr_dat;
    assign ifs.rd_req = rd_req;

    sc_fifo #(
        .DAT_WIDTH (DW), .ADDR_WIDTH (AW), .SHOW_AHEAD (0),
        .AF_LEVEL  (AF), .AE_LEVEL   (AE)
    ) dut_n (
        .clk (clk), .aclr_n (aclr_n), .bus (ifn)
    );

    sc_fifo #(
        .DAT_WIDTH (DW), .ADDR_WIDTH (AW), .SHOW_AHEAD (1),
        .AF_LEVEL  (AF), .AE_LEVEL   (AE)
    ) dut_s (
        .clk (clk), .aclr_n (aclr_n), .bus (ifs)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy counts, show-ahead head-valid bit, flags.
    int            n_size = 0;
    int            s_size = 0;
    bit            s_qv   = 0;
    bit            n_ovf  = 0;
    bit            n_unf  = 0;
    bit            s_ovf  = 0;
    bit            s_unf  = 0;
    logic [DW-1:0] sb_n [$];
    logic [DW-1:0] sb_s [$];
    bit            n_pend = 0;
    logic [DW-1:0] n_pend_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_size = 0; s_size = 0; s_qv = 0;
        n_ovf = 0; n_unf = 0; s_ovf = 0; s_unf = 0;
        sb_n.delete();
        sb_s.delete();
    endtask

    // One clock edge of the specified behaviour, from pre-edge state.
    task automatic model_edge();
        bit w_ok;
        bit pop;
        bit nq;
        int d;
        if (sclr) begin
            model_reset();
            return;
        end
        // normal mode
        w_ok = wr_req && (n_size < DEPTH);
        if (wr_req && n_size == DEPTH) n_ovf = 1;
        if (rd_req && n_size == 0)     n_unf = 1;
        if (w_ok) sb_n.push_back(wr_dat);
        d = 0;
        if (w_ok) d++;
        if (rd_req && n_size > 0) d--;
        n_size += d;
        // show-ahead mode: head becomes visible one edge after a word
        // exists behind it; a pop keeps it visible only if another word
        // was already stored before this edge
        w_ok = wr_req && (s_size < DEPTH);
        pop  = rd_req && s_qv;
        if (wr_req && s_size == DEPTH) s_ovf = 1;
        if (rd_req && !s_qv)           s_unf = 1;
        if (w_ok) sb_s.push_back(wr_dat);
        nq = s_qv ? (pop ? (s_size > 1) : 1'b1) : (s_size > 0);
        d = 0;
        if (w_ok) d++;
        if (pop)  d--;
        s_size += d;
        s_qv = nq;
    endtask

    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit s);
        wr_req = w;
        wr_dat = d;
        rd_req = r;
        sclr   = s;
        @(posedge clk);
        if (aclr_n) model_edge();
        #2;
    endtask

    task automatic check_status(input string tag, input logic [AW:0] used,
                                input logic empty, input logic full,
                                input logic af, input logic ae,
                                input logic ov, input logic un,
                                input int size, input bit e_empty,
                                input bit e_ov, input bit e_un);
        check({tag, ".used"},         32'(used),  32'(size));
        check({tag, ".rd_empty"},     32'(empty), 32'(e_empty));
        check({tag, ".wr_full"},      32'(full),  32'(size == DEPTH));
        check({tag, ".almost_full"},  32'(af),    32'(size >= AF));
        check({tag, ".almost_empty"}, 32'(ae),    32'(size <= AE));
        check({tag, ".overflow"},     32'(ov),    32'(e_ov));
        check({tag, ".underflow"},    32'(un),    32'(e_un));
    endtask

    // Monitor: status every cycle, data on each read handshake.
    always @(negedge clk) begin
        check_status("n", ifn.used, ifn.rd_empty, ifn.wr_full, ifn.almost_full,
                     ifn.almost_empty, ifn.overflow, ifn.underflow,
                     n_size, (n_size == 0), n_ovf, n_unf);
        check_status("s", ifs.used, ifs.rd_empty, ifs.wr_full, ifs.almost_full,
                     ifs.almost_empty, ifs.overflow, ifs.underflow,
                     s_size, !s_qv, s_ovf, s_unf);
        if (n_pend) begin
            check("n.rd_dat", ifn.rd_dat, n_pend_exp);
            n_pend = 0;
        end
        if (aclr_n && !sclr && rd_req && !ifn.rd_empty) begin
            if (sb_n.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL n.rd_handshake: read accepted, got none expected a queued word");
            end else begin
                n_pend_exp = sb_n.pop_front();
                n_pend     = 1;
            end
        end
        if (aclr_n && !sclr && rd_req && !ifs.rd_empty) begin
            if (sb_s.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL s.rd_handshake: pop accepted, got none expected a queued word");
            end else begin
                check("s.rd_dat", ifs.rd_dat, sb_s.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        #22 aclr_n = 1'b1;
        @(posedge clk);
        #2;
        repeat (2) cycle(0, '0, 0, 0);

        // fill to full, one overflowing write, drain, one underflowing read
        for (int i = 1; i <= 8; i++) cycle(1, DW'(i), 0, 0);
        cycle(1, 32'h9, 0, 0);
        cycle(0, '0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0);
        repeat (2) cycle(0, '0, 0, 0);
        cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 0);

        // sclr mid-burst with a write in the same cycle
        for (int i = 0; i < 3; i++) cycle(1, 32'h100 + DW'(i), 0, 0);
        cycle(1, 32'h1FF, 0, 1);
        for (int i = 0; i < 2; i++) cycle(1, 32'h200 + DW'(i), 0, 0);
        cycle(0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 1);

        // steady occupancy of 3 with simultaneous read and write
        for (int i = 0; i < 3; i++) cycle(1, 32'h300 + DW'(i), 0, 0);
        cycle(0, '0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 32'h400 + DW'(i), 1, 0);
        repeat (4) cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 1);

        // asynchronous reset pulse between edges at used=5
        for (int i = 0; i < 5; i++) cycle(1, 32'h500 + DW'(i), 0, 0);
        cycle(0, '0, 0, 0);
        #1 aclr_n = 1'b0;
        #1;
        model_reset();
        check_status("n.aclr", ifn.used, ifn.rd_empty, ifn.wr_full, ifn.almost_full,
                     ifn.almost_empty, ifn.overflow, ifn.underflow, 0, 1, 0, 0);
        check_status("s.aclr", ifs.used, ifs.rd_empty, ifs.wr_full, ifs.almost_full,
                     ifs.almost_empty, ifs.overflow, ifs.underflow, 0, 1, 0, 0);
        check("n.aclr.rd_dat", ifn.rd_dat, '0);
        check("s.aclr.rd_dat", ifs.rd_dat, '0);
        #3 aclr_n = 1'b1;

        // random traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 1500; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 70 : 30;
            cycle($urandom_range(99) < 32'(wp), DW'($urandom),
                  $urandom_range(99) < 32'(100 - wp), $urandom_range(199) == 0);
        end
        repeat (3) cycle(0, '0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
